// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B.
// Optional macro RAM_ARB_STATS_EN adds a saturating contention counter (conflict_cnt).
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
`ifdef RAM_ARB_STATS_EN
  output logic [15:0]           conflict_cnt,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  state_t                state, state_nxt;
  logic                  last_b, last_b_nxt;   // 1: B held the most recent grant
  logic                  cur_b, cur_b_nxt;     // owner of the transaction in flight
  logic                  gnt_a_nxt, gnt_b_nxt;
  logic                  rvalid_a_nxt, rvalid_b_nxt;
  logic                  mem_en_nxt, mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;
  logic [DATA_WIDTH-1:0] rdata_a_nxt, rdata_b_nxt;
  logic                  pick_b;

  // B wins when it is the only requester, or on contention after an A grant.
  assign pick_b = req_b & (~req_a | ~last_b);

  always_comb begin
    state_nxt     = state;
    last_b_nxt    = last_b;
    cur_b_nxt     = cur_b;
    gnt_a_nxt     = 1'b0;
    gnt_b_nxt     = 1'b0;
    rvalid_a_nxt  = 1'b0;
    rvalid_b_nxt  = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    rdata_a_nxt   = rdata_a;
    rdata_b_nxt   = rdata_b;
    case (state)
      IDLE: begin
        if (req_a | req_b) begin
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = pick_b ? we_b    : we_a;
          mem_addr_nxt  = pick_b ? addr_b  : addr_a;
          mem_wdata_nxt = pick_b ? wdata_b : wdata_a;
          gnt_a_nxt     = ~pick_b;
          gnt_b_nxt     = pick_b;
          last_b_nxt    = pick_b;
          cur_b_nxt     = pick_b;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = mem_we ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        if (cur_b) begin
          rdata_b_nxt  = mem_rdata;
          rvalid_b_nxt = 1'b1;
        end else begin
          rdata_a_nxt  = mem_rdata;
          rvalid_a_nxt = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      cur_b     <= 1'b0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_a   <= '0;
      rdata_b   <= '0;
    end else begin
      state     <= state_nxt;
      last_b    <= last_b_nxt;
      cur_b     <= cur_b_nxt;
      gnt_a     <= gnt_a_nxt;
      gnt_b     <= gnt_b_nxt;
      rvalid_a  <= rvalid_a_nxt;
      rvalid_b  <= rvalid_b_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      rdata_a   <= rdata_a_nxt;
      rdata_b   <= rdata_b_nxt;
    end
  end

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      conflict_cnt <= '0;
    else if ((state == IDLE) && req_a && req_b && (conflict_cnt != 16'hFFFF))
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed commands push expected grants/read data,
// a negedge monitor pops and compares them; a small RAM model answers mem_* accesses.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, we_a, req_b, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic       mem_en, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
`ifdef RAM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic ram_init;
  logic [7:0] ram [16];

  typedef struct {
    logic       is_b;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       abort;
  } txn_t;

  typedef struct {
    logic [7:0] rdata;
    int         cyc;
  } pend_t;

  txn_t  exp_gnt[$];
  pend_t pend_a[$];
  pend_t pend_b[$];

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
`ifdef RAM_ARB_STATS_EN
    .conflict_cnt(conflict_cnt),
`endif
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM preloaded with ram[i] = i * 8'h11.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'(i * 17);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad_event(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_txn(input logic is_b, input logic we, input logic [3:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rdata, input logic abort);
    txn_t t;
    t.is_b = is_b; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.abort = abort;
    exp_gnt.push_back(t);
  endtask

  // Present one command and hold it until the matching grant is seen.
  task automatic do_cmd(input logic is_b, input logic we, input logic [3:0] addr,
                        input logic [7:0] wdata, output int waits);
    logic got;
    got = 1'b0;
    waits = 0;
    if (is_b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; end
    else      begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; end
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      waits++;
      got = is_b ? gnt_b : gnt_a;
    end
    if (!got) bad_event(is_b ? "gnt_b timeout" : "gnt_a timeout");
  endtask

  task automatic idle_side(input logic is_b);
    if (is_b) req_b = 1'b0;
    else      req_a = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst gnt_a", 32'(gnt_a), 0);
    chk("rst gnt_b", 32'(gnt_b), 0);
    chk("rst rvalid_a", 32'(rvalid_a), 0);
    chk("rst rvalid_b", 32'(rvalid_b), 0);
    chk("rst mem_en", 32'(mem_en), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_wdata", 32'(mem_wdata), 0);
    chk("rst rdata_a", 32'(rdata_a), 0);
    chk("rst rdata_b", 32'(rdata_b), 0);
`ifdef RAM_ARB_STATS_EN
    chk("rst conflict_cnt", 32'(conflict_cnt), 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs();
    rst = 1'b0;
  endtask

  // Monitor: grants are checked against the expected order and RAM command,
  // read data against the pending queue of the matching requester.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mem_en vs gnt", 32'(mem_en), 32'(gnt_a | gnt_b));
      if (gnt_a && gnt_b) bad_event("gnt_a and gnt_b together");
      else if (gnt_a || gnt_b) begin
        if (exp_gnt.size() == 0) bad_event("unexpected grant");
        else begin
          txn_t  t;
          pend_t p;
          t = exp_gnt.pop_front();
          chk("gnt owner is_b", 32'(gnt_b), 32'(t.is_b));
          chk("mem_we", 32'(mem_we), 32'(t.we));
          chk("mem_addr", 32'(mem_addr), 32'(t.addr));
          if (t.we) chk("mem_wdata", 32'(mem_wdata), 32'(t.wdata));
          if (!t.we && !t.abort) begin
            p.rdata = t.rdata;
            p.cyc   = cyc;
            if (t.is_b) pend_b.push_back(p);
            else        pend_a.push_back(p);
          end
        end
      end
      if (rvalid_a) begin
        if (pend_a.size() == 0) bad_event("unexpected rvalid_a");
        else begin
          pend_t p;
          p = pend_a.pop_front();
          chk("rdata_a", 32'(rdata_a), 32'(p.rdata));
          chk("rvalid_a latency", 32'(cyc - p.cyc), 2);
        end
      end
      if (rvalid_b) begin
        if (pend_b.size() == 0) bad_event("unexpected rvalid_b");
        else begin
          pend_t p;
          p = pend_b.pop_front();
          chk("rdata_b", 32'(rdata_b), 32'(p.rdata));
          chk("rvalid_b latency", 32'(cyc - p.cyc), 2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst = 1'b1; ram_init = 1'b1;
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    @(posedge clk); #1;
    ram_init = 1'b0;
    do_reset();

    // A writes A5 to addr 3, then B reads it back.
    push_txn(0, 1, 4'h3, 8'hA5, 8'h00, 0);
    do_cmd(0, 1, 4'h3, 8'hA5, w);
    chk("write gnt latency", 32'(w), 1);
    idle_side(0);
    @(posedge clk); #1;
    push_txn(1, 0, 4'h3, 8'h00, 8'hA5, 0);
    do_cmd(1, 0, 4'h3, 8'h00, w);
    chk("read gnt latency", 32'(w), 1);
    idle_side(1);
    repeat (4) @(posedge clk);
    #1;

    // Contention from reset: strict A, B alternation.
    do_reset();
    push_txn(0, 0, 4'h5, 0, 8'h55, 0);
    push_txn(1, 0, 4'h8, 0, 8'h88, 0);
    push_txn(0, 0, 4'h6, 0, 8'h66, 0);
    push_txn(1, 0, 4'h9, 0, 8'h99, 0);
    push_txn(0, 0, 4'h7, 0, 8'h77, 0);
    push_txn(1, 0, 4'hA, 0, 8'hAA, 0);
    fork
      begin
        int wa;
        do_cmd(0, 0, 4'h5, 0, wa);
        do_cmd(0, 0, 4'h6, 0, wa);
        do_cmd(0, 0, 4'h7, 0, wa);
        idle_side(0);
      end
      begin
        int wb;
        do_cmd(1, 0, 4'h8, 0, wb);
        do_cmd(1, 0, 4'h9, 0, wb);
        do_cmd(1, 0, 4'hA, 0, wb);
        idle_side(1);
      end
    join
    repeat (5) @(posedge clk);
    #1;
`ifdef RAM_ARB_STATS_EN
    chk("conflict_cnt after contention", 32'(conflict_cnt), 5);
`endif

    // A streams reads 0..3 alone: one grant every 3 cycles; addr 3 holds A5.
    push_txn(0, 0, 4'h0, 0, 8'h00, 0);
    push_txn(0, 0, 4'h1, 0, 8'h11, 0);
    push_txn(0, 0, 4'h2, 0, 8'h22, 0);
    push_txn(0, 0, 4'h3, 0, 8'hA5, 0);
    do_cmd(0, 0, 4'h0, 0, w);
    chk("stream first gnt", 32'(w), 1);
    for (int i = 1; i < 4; i++) begin
      do_cmd(0, 0, 4'(i), 0, w);
      chk("stream gnt spacing", 32'(w), 3);
    end
    idle_side(0);
    repeat (5) @(posedge clk);
    #1;
`ifdef RAM_ARB_STATS_EN
    chk("conflict_cnt held", 32'(conflict_cnt), 5);
`endif

    // Reset during RDWAIT of an A read: its rvalid must never appear.
    push_txn(0, 0, 4'h1, 0, 8'h11, 1);
    do_cmd(0, 0, 4'h1, 0, w);
    idle_side(0);
    @(posedge clk); #1;
    do_reset();
    repeat (4) @(posedge clk);
    #1;

    // Last grant before reset was A, so A winning here shows last_grant returned to B.
    push_txn(0, 0, 4'h2, 0, 8'h22, 0);
    push_txn(1, 0, 4'h4, 0, 8'h44, 0);
    fork
      begin
        int wa;
        do_cmd(0, 0, 4'h2, 0, wa);
        idle_side(0);
      end
      begin
        int wb;
        do_cmd(1, 0, 4'h4, 0, wb);
        idle_side(1);
      end
    join
    repeat (5) @(posedge clk);
    #1;
`ifdef RAM_ARB_STATS_EN
    chk("conflict_cnt after reset", 32'(conflict_cnt), 1);
`endif

    chk("grants outstanding", 32'(exp_gnt.size()), 0);
    chk("reads outstanding a", 32'(pend_a.size()), 0);
    chk("reads outstanding b", 32'(pend_b.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Round-robin arbiter that shares one single-port synchronous RAM between two requesters, A and B. Each requester issues read/write commands with a req/gnt handshake. Read data returns to the requester that issued the command, with an rvalid pulse. The block sits between the two client masters and the RAM, and it sequences every RAM access: enable, write-enable, address, write data and read-data capture.

Parameters:
DATA_WIDTH, 8, width of write/read data on all ports
ADDR_WIDTH, 4, RAM address width (depth = 2**ADDR_WIDTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_a  input  1  requester A command valid; held with payload until gnt_a
we_a  input  1  A: 1 = write, 0 = read
addr_a  input  ADDR_WIDTH  A address
wdata_a  input  DATA_WIDTH  A write data
gnt_a  output  1  one-cycle pulse: A command accepted
rvalid_a  output  1  one-cycle pulse: rdata_a valid
rdata_a  output  DATA_WIDTH  A read data
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  as A, for requester B
mem_en  output  1  RAM access enable
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_WIDTH  RAM address
mem_wdata  output  DATA_WIDTH  RAM write data
mem_rdata  input  DATA_WIDTH  RAM read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); polarity and synchronicity are fixed.
- All outputs are registered.
- Reset values:
  - gnt_a/b, rvalid_a/b, mem_en, mem_we = 0
  - mem_addr, mem_wdata, rdata_a/b = 0
  - state = IDLE
  - last_grant = B, so A wins the first contention.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - If no req: stay in IDLE; mem_en = 0.
  - If any req: select the winner, register its we/addr/wdata onto mem_*, set mem_en = 1 and gnt_winner = 1 for the next cycle, update last_grant, go to ACCESS.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last_grant wins.
  - The loser keeps req asserted and is served at the next IDLE.
- ACCESS (exactly one cycle):
  - mem_en = 1 and gnt_x = 1 in this cycle.
  - Next cycle: mem_en = 0, gnt = 0.
  - Write: go to IDLE.
  - Read: go to RDWAIT.
- RDWAIT (one cycle): capture mem_rdata into rdata_x of the granted requester. Assert rvalid_x for one cycle in the following cycle. Go to IDLE.
- Latency, with req sampled in cycle N:
  - Write: gnt/mem_en in N+1; next command can be sampled in N+2.
  - Read: gnt/mem_en in N+1, mem_rdata in N+2, rvalid/rdata in N+3, IDLE sampled in N+3.
- Handshake:
  - The requester holds req/we/addr/wdata stable until it sees gnt.
  - In the cycle after gnt, the requester drops req or presents a new command.
  - Payload sampled outside IDLE is ignored.
  - rdata_x holds its last value until the next read completes for that requester.
- The non-granted requester's gnt/rvalid stay 0 throughout the transaction.
- Back-to-back reads from one requester with no competitor: one command every 3 cycles.
- Alternating contention: strict A, B, A, B order.
- Reset mid-operation (ACCESS or RDWAIT):
  - Next cycle all outputs are at reset values and state = IDLE.
  - The pending rvalid is dropped; no late rvalid appears after reset.
  - last_grant returns to B.
- Address/data pass through without modification; no wrap or arithmetic is applied to addresses.

Optional Feature:
Macro RAM_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt [15:0], a saturating counter, 0 on reset.
  - Increments in every IDLE cycle in which req_a and req_b are both 1.
  - Holds at 16'hFFFF once saturated.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then A writes addr 4'h3 data 8'hA5 -> gnt_a in N+1 with mem_en=1, mem_we=1, mem_addr=3, mem_wdata=A5; gnt_b=0.
- B reads addr 4'h3 after that write -> gnt_b in N+1, mem_we=0; rvalid_b in N+3 with rdata_b=8'hA5; rvalid_a stays 0.
- req_a and req_b both asserted from reset, each holding 3 reads -> grant order A, B, A, B, A, B; each gnt is followed by rvalid to the matching requester 2 cycles later.
- A continuous reads at addr 0..3 with B idle -> gnt_a every 3 cycles, rdata_a = RAM contents in order; no B outputs.
- rst asserted during RDWAIT of an A read -> next cycle all outputs are 0 and state is IDLE; no rvalid_a appears afterward; the next contention is won by A.
- RAM_ARB_STATS_EN defined, both requesters held high for 4 transactions -> conflict_cnt equals the number of IDLE cycles with both reqs high (4); value is preserved until reset, after which it returns to 0.
